floo_wide_burst_tx: RTL and testbench



---
 rtl/floo_wide_burst_tx.sv | 219 +++++++++++++++++++++
 tb/tb_floo_wide_burst_tx.sv | 533 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/floo_wide_burst_tx.sv
// -----------------------------------------------------------------------------
// floo_wide_burst_tx
//
// Injection-side transmitter for the wide link. A burst descriptor
// (destination, length) is accepted, then one wide flit is emitted per payload
// beat. Each flit carries a routing header: dst, src (own id at capture), seq
// (beat index within the burst) and last. The block also counts bursts that
// have been issued but not yet acknowledged end-to-end by the far endpoint.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   id_i                     own node id, copied into the src field
//   burst_valid_i/ready_o    descriptor handshake; burst_dst_i, burst_len_i
//                            (beats minus one)
//   data_valid_i/ready_o     payload beat handshake; data_i
//   flit_valid_o/ready_i     flit handshake toward the router; flit_data_o,
//                            flit_dst_o, flit_src_o, flit_seq_o, flit_last_o
//   ack_valid_i              one-cycle pulse: one burst completed at far end
//   outstanding_o            bursts issued but not yet acknowledged
//   err_o                    sticky: ack received with nothing outstanding
//
// Optional feature (macro FLOO_WIDE_BURST_TX_PERF_EN):
//   perf_flits_o             saturating count of flit handshakes
//   perf_stall_o             saturating count of cycles with valid && !ready
// -----------------------------------------------------------------------------
module floo_wide_burst_tx #(
    parameter int unsigned IdWidth        = 4,
    parameter int unsigned DataWidth      = 512,
    parameter int unsigned LenWidth       = 8,
    parameter int unsigned MaxOutstanding = 4,
    parameter int unsigned CntWidth       = $clog2(MaxOutstanding + 1)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [IdWidth-1:0]   id_i,
    // burst descriptor
    input  logic                 burst_valid_i,
    output logic                 burst_ready_o,
    input  logic [IdWidth-1:0]   burst_dst_i,
    input  logic [LenWidth-1:0]  burst_len_i,
    // payload beats
    input  logic                 data_valid_i,
    output logic                 data_ready_o,
    input  logic [DataWidth-1:0] data_i,
    // flits toward the router
    output logic                 flit_valid_o,
    input  logic                 flit_ready_i,
    output logic [DataWidth-1:0] flit_data_o,
    output logic [IdWidth-1:0]   flit_dst_o,
    output logic [IdWidth-1:0]   flit_src_o,
    output logic [LenWidth-1:0]  flit_seq_o,
    output logic                 flit_last_o,
    // end-to-end completion tracking
    input  logic                 ack_valid_i,
    output logic [CntWidth-1:0]  outstanding_o,
    output logic                 err_o
`ifdef FLOO_WIDE_BURST_TX_PERF_EN
    ,
    output logic [31:0]          perf_flits_o,
    output logic [31:0]          perf_stall_o
`endif
);

    typedef enum logic {
        IDLE   = 1'b0,
        STREAM = 1'b1
    } state_e;

    localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

    // Control state
    state_e               state_q;
    logic [IdWidth-1:0]   dst_q;
    logic [LenWidth-1:0]  len_q;
    logic [LenWidth-1:0]  beat_cnt_q;
    logic [CntWidth-1:0]  outstanding_q;
    logic                 err_q;

    // Output register
    logic                 flit_valid_q;
    logic [DataWidth-1:0] flit_data_q;
    logic [IdWidth-1:0]   flit_dst_q;
    logic [IdWidth-1:0]   flit_src_q;
    logic [LenWidth-1:0]  flit_seq_q;
    logic                 flit_last_q;

    logic out_free;
    logic burst_hs;
    logic data_hs;
    logic flit_hs;
    logic beat_last;

    // The output register can take a new beat when it is empty or when its
    // current flit leaves this cycle, which gives one flit per cycle.
    assign out_free  = !flit_valid_q || flit_ready_i;
    assign beat_last = (beat_cnt_q == len_q);

    // The ready outputs are decoded from state; gating with rst_i keeps them
    // low for the whole reset window, not only after the first reset edge.
    assign burst_ready_o = !rst_i && (state_q == IDLE) && (outstanding_q < MaxCnt);
    assign data_ready_o  = !rst_i && (state_q == STREAM) && out_free;

    assign burst_hs = burst_valid_i && burst_ready_o;
    assign data_hs  = data_valid_i && data_ready_o;
    assign flit_hs  = flit_valid_q && flit_ready_i;

    // -------------------------------------------------------------------------
    // Burst FSM, output register and outstanding counter
    // -------------------------------------------------------------------------
    // NOTE: every register in a clocked block is written with <= so all of them
    // sample the pre-edge values; a blocking = here would let later statements
    // see half-updated state.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            dst_q         <= '0;
            len_q         <= '0;
            beat_cnt_q    <= '0;
            outstanding_q <= '0;
            err_q         <= 1'b0;
            flit_valid_q  <= 1'b0;
            // NOTE: the wide payload register is cleared on purpose: the flit
            // fields must read 0 in reset, so it cannot be left unreset like
            // plain datapath storage.
            flit_data_q   <= '0;
            flit_dst_q    <= '0;
            flit_src_q    <= '0;
            flit_seq_q    <= '0;
            flit_last_q   <= 1'b0;
        end else begin
            // Sequencing of the burst
            case (state_q)
                IDLE: begin
                    if (burst_hs) begin
                        dst_q      <= burst_dst_i;
                        len_q      <= burst_len_i;
                        beat_cnt_q <= '0;
                        state_q    <= STREAM;
                    end
                end
                STREAM: begin
                    if (data_hs) begin
                        // The counter stops on the last beat, so a maximum
                        // length burst never wraps it.
                        if (beat_last) begin
                            state_q <= IDLE;
                        end else begin
                            beat_cnt_q <= beat_cnt_q + 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase

            // Output register: a new beat takes priority over draining, which
            // covers the case of a flit leaving while the next one loads.
            if (data_hs) begin
                flit_valid_q <= 1'b1;
                flit_data_q  <= data_i;
                flit_dst_q   <= dst_q;
                flit_src_q   <= id_i;
                flit_seq_q   <= beat_cnt_q;
                flit_last_q  <= beat_last;
            end else if (flit_hs) begin
                flit_valid_q <= 1'b0;
            end

            // Outstanding bursts: a handshake and an ack in the same cycle
            // cancel. Overflow is impossible because burst_ready_o drops at
            // the limit.
            case ({burst_hs, ack_valid_i})
                2'b10: outstanding_q <= outstanding_q + CntWidth'(1);
                2'b01: begin
                    if (outstanding_q == '0) begin
                        err_q <= 1'b1;
                    end else begin
                        outstanding_q <= outstanding_q - CntWidth'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    assign flit_valid_o  = flit_valid_q;
    assign flit_data_o   = flit_data_q;
    assign flit_dst_o    = flit_dst_q;
    assign flit_src_o    = flit_src_q;
    assign flit_seq_o    = flit_seq_q;
    assign flit_last_o   = flit_last_q;
    assign outstanding_o = outstanding_q;
    assign err_o         = err_q;

`ifdef FLOO_WIDE_BURST_TX_PERF_EN
    // -------------------------------------------------------------------------
    // Performance counters (saturating)
    // -------------------------------------------------------------------------
    logic [31:0] perf_flits_q;
    logic [31:0] perf_stall_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            perf_flits_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (flit_hs && (perf_flits_q != '1)) begin
                perf_flits_q <= perf_flits_q + 32'd1;
            end
            if (flit_valid_q && !flit_ready_i && (perf_stall_q != '1)) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_flits_o = perf_flits_q;
    assign perf_stall_o = perf_stall_q;
`endif

endmodule

// File: tb/tb_floo_wide_burst_tx.sv
// -----------------------------------------------------------------------------
// Testbench for floo_wide_burst_tx (default parameters).
// A reference model tracks the transmitter at transaction level: a queue of
// expected flits built from accepted beats, the number of beats still owed to
// the current burst, the outstanding-burst count and the sticky error. Every
// cycle the DUT outputs are compared with the model; directed sequences and a
// vector table add explicit checks for the corner cases.
// -----------------------------------------------------------------------------
module tb_floo_wide_burst_tx;

    localparam int IW = 4;
    localparam int DW = 512;
    localparam int LW = 8;
    localparam int MO = 4;
    localparam int CW = $clog2(MO + 1);

    logic          clk_i;
    logic          rst_i;
    logic [IW-1:0] id_i;
    logic          burst_valid_i;
    logic          burst_ready_o;
    logic [IW-1:0] burst_dst_i;
    logic [LW-1:0] burst_len_i;
    logic          data_valid_i;
    logic          data_ready_o;
    logic [DW-1:0] data_i;
    logic          flit_valid_o;
    logic          flit_ready_i;
    logic [DW-1:0] flit_data_o;
    logic [IW-1:0] flit_dst_o;
    logic [IW-1:0] flit_src_o;
    logic [LW-1:0] flit_seq_o;
    logic          flit_last_o;
    logic          ack_valid_i;
    logic [CW-1:0] outstanding_o;
    logic          err_o;
`ifdef FLOO_WIDE_BURST_TX_PERF_EN
    logic [31:0]   perf_flits_o;
    logic [31:0]   perf_stall_o;
`endif

    floo_wide_burst_tx #(
        .IdWidth       (IW),
        .DataWidth     (DW),
        .LenWidth      (LW),
        .MaxOutstanding(MO)
    ) dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .id_i          (id_i),
        .burst_valid_i (burst_valid_i),
        .burst_ready_o (burst_ready_o),
        .burst_dst_i   (burst_dst_i),
        .burst_len_i   (burst_len_i),
        .data_valid_i  (data_valid_i),
        .data_ready_o  (data_ready_o),
        .data_i        (data_i),
        .flit_valid_o  (flit_valid_o),
        .flit_ready_i  (flit_ready_i),
        .flit_data_o   (flit_data_o),
        .flit_dst_o    (flit_dst_o),
        .flit_src_o    (flit_src_o),
        .flit_seq_o    (flit_seq_o),
        .flit_last_o   (flit_last_o),
        .ack_valid_i   (ack_valid_i),
        .outstanding_o (outstanding_o),
        .err_o         (err_o)
`ifdef FLOO_WIDE_BURST_TX_PERF_EN
        ,
        .perf_flits_o  (perf_flits_o),
        .perf_stall_o  (perf_stall_o)
`endif
    );

    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------------------
    // Bookkeeping
    // -------------------------------------------------------------------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [DW-1:0] got,
                         input logic [DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // -------------------------------------------------------------------------
    // Reference model
    // -------------------------------------------------------------------------
    typedef struct {
        logic [DW-1:0] data;
        logic [IW-1:0] dst;
        logic [IW-1:0] src;
        logic [LW-1:0] seq;
        logic          last;
    } flit_t;

    flit_t         exp_q[$];
    bit            mon_en       = 1'b0;
    bit            m_valid      = 1'b0;
    int            m_beats_left = 0;
    int            m_seq        = 0;
    logic [IW-1:0] m_dst        = '0;
    int            m_out        = 0;
    bit            m_err        = 1'b0;
    bit            last_b_hs    = 1'b0;
    int            n_flits      = 0;
`ifdef FLOO_WIDE_BURST_TX_PERF_EN
    int            m_pflits     = 0;
    int            m_pstall     = 0;
`endif

    // Called once per cycle with inputs settled: compare, then advance the
    // model by what the coming clock edge does.
    task automatic monitor();
        bit    exp_br;
        bit    exp_dr;
        bit    b_hs;
        bit    d_hs;
        bit    f_hs;
        flit_t f;
        last_b_hs = 1'b0;
        if (!mon_en) return;

        exp_br = !rst_i && (m_beats_left == 0) && (m_out < MO);
        exp_dr = !rst_i && (m_beats_left > 0) && (!m_valid || flit_ready_i);
        check("burst_ready", burst_ready_o, exp_br);
        check("data_ready", data_ready_o, exp_dr);
        check("flit_valid", flit_valid_o, m_valid);
        check("outstanding", outstanding_o, m_out);
        check("err", err_o, m_err);
`ifdef FLOO_WIDE_BURST_TX_PERF_EN
        check("perf_flits", perf_flits_o, m_pflits);
        check("perf_stall", perf_stall_o, m_pstall);
`endif
        if (m_valid && exp_q.size() > 0) begin
            f = exp_q[0];
            check("flit_data", flit_data_o, f.data);
            check("flit_dst", flit_dst_o, f.dst);
            check("flit_src", flit_src_o, f.src);
            check("flit_seq", flit_seq_o, f.seq);
            check("flit_last", flit_last_o, f.last);
        end

        if (rst_i) begin
            exp_q.delete();
            m_valid      = 1'b0;
            m_beats_left = 0;
            m_seq        = 0;
            m_out        = 0;
            m_err        = 1'b0;
`ifdef FLOO_WIDE_BURST_TX_PERF_EN
            m_pflits     = 0;
            m_pstall     = 0;
`endif
            return;
        end

        b_hs = burst_valid_i && exp_br;
        d_hs = data_valid_i && exp_dr;
        f_hs = m_valid && flit_ready_i;
        last_b_hs = b_hs;

`ifdef FLOO_WIDE_BURST_TX_PERF_EN
        if (f_hs) m_pflits++;
        if (m_valid && !flit_ready_i) m_pstall++;
`endif
        if (f_hs) begin
            exp_q.delete(0);
            n_flits++;
            m_valid = 1'b0;
        end
        if (d_hs) begin
            f.data = data_i;
            f.dst  = m_dst;
            f.src  = id_i;
            f.seq  = LW'(m_seq);
            f.last = (m_beats_left == 1);
            exp_q.push_back(f);
            m_valid = 1'b1;
            m_beats_left--;
            m_seq++;
        end
        if (b_hs) begin
            m_beats_left = int'(burst_len_i) + 1;
            m_dst        = burst_dst_i;
            m_seq        = 0;
        end
        if (b_hs && !ack_valid_i) begin
            m_out++;
        end else if (ack_valid_i && !b_hs) begin
            if (m_out == 0) m_err = 1'b1;
            else            m_out--;
        end
    endtask

    // One clock cycle: settle, model/compare, edge, then step off the edge.
    task automatic tick();
        #1;
        monitor();
        @(posedge clk_i);
        #1;
    endtask

    function automatic logic [DW-1:0] rand_data();
        logic [DW-1:0] r;
        for (int i = 0; i < DW / 32; i++) r[i*32 +: 32] = $urandom;
        return r;
    endfunction

    task automatic ack_pulse();
        ack_valid_i = 1'b1;
        tick();
        ack_valid_i = 1'b0;
    endtask

    // Issue one burst with the router always ready and beats always valid.
    task automatic send_burst(input logic [IW-1:0] dst, input logic [LW-1:0] len);
        bit acc;
        acc           = 1'b0;
        flit_ready_i  = 1'b1;
        burst_valid_i = 1'b1;
        burst_dst_i   = dst;
        burst_len_i   = len;
        for (int g = 0; g < 50 && !acc; g++) begin
            tick();
            acc = last_b_hs;
        end
        burst_valid_i = 1'b0;
        check("send_burst_accepted", acc, 1'b1);
        data_valid_i = 1'b1;
        for (int g = 0; g < 600 && (m_beats_left > 0); g++) begin
            data_i = rand_data();
            tick();
        end
        data_valid_i = 1'b0;
        check("send_burst_beats_done", m_beats_left, 0);
    endtask

    // -------------------------------------------------------------------------
    // Vector table: single-beat bursts with expected header and counter values
    // -------------------------------------------------------------------------
    typedef struct {
        logic [IW-1:0] id;
        logic [IW-1:0] dst;
        logic [DW-1:0] data;
        logic          ack;
        logic [IW-1:0] exp_dst;
        logic [IW-1:0] exp_src;
        logic [LW-1:0] exp_seq;
        logic          exp_last;
        logic [CW-1:0] exp_out_flit;
        logic [CW-1:0] exp_out_end;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [DW-1:0] d[4];
        int            base;

        vecs[0] = '{id: 4'd3,  dst: 4'd5,  data: {64{8'hA5}}, ack: 1'b1,
                    exp_dst: 4'd5,  exp_src: 4'd3,  exp_seq: 8'd0, exp_last: 1'b1,
                    exp_out_flit: 3'd1, exp_out_end: 3'd0};
        vecs[1] = '{id: 4'd7,  dst: 4'd0,  data: '0, ack: 1'b0,
                    exp_dst: 4'd0,  exp_src: 4'd7,  exp_seq: 8'd0, exp_last: 1'b1,
                    exp_out_flit: 3'd1, exp_out_end: 3'd1};
        vecs[2] = '{id: 4'd15, dst: 4'd15, data: '1, ack: 1'b0,
                    exp_dst: 4'd15, exp_src: 4'd15, exp_seq: 8'd0, exp_last: 1'b1,
                    exp_out_flit: 3'd2, exp_out_end: 3'd2};
        vecs[3] = '{id: 4'd0,  dst: 4'd9,  data: 512'h0123_4567_89ab_cdef_fedc_ba98, ack: 1'b1,
                    exp_dst: 4'd9,  exp_src: 4'd0,  exp_seq: 8'd0, exp_last: 1'b1,
                    exp_out_flit: 3'd3, exp_out_end: 3'd2};

        rst_i         = 1'b1;
        id_i          = '0;
        burst_valid_i = 1'b0;
        burst_dst_i   = '0;
        burst_len_i   = '0;
        data_valid_i  = 1'b0;
        data_i        = '0;
        flit_ready_i  = 1'b0;
        ack_valid_i   = 1'b0;

        // ---- Reset state ----
        @(posedge clk_i);
        #1;
        mon_en = 1'b1;
        check("rst_flit_valid", flit_valid_o, 1'b0);
        check("rst_flit_data", flit_data_o, '0);
        check("rst_flit_dst", flit_dst_o, '0);
        check("rst_flit_src", flit_src_o, '0);
        check("rst_flit_seq", flit_seq_o, '0);
        check("rst_flit_last", flit_last_o, 1'b0);
        check("rst_outstanding", outstanding_o, '0);
        check("rst_err", err_o, 1'b0);
        tick();
        rst_i = 1'b0;

        // ---- Table: single-beat bursts ----
        flit_ready_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            id_i          = vecs[i].id;
            burst_dst_i   = vecs[i].dst;
            burst_len_i   = '0;
            burst_valid_i = 1'b1;
            tick();
            burst_valid_i = 1'b0;
            data_valid_i  = 1'b1;
            data_i        = vecs[i].data;
            tick();
            data_valid_i  = 1'b0;
            check("vec_flit_valid", flit_valid_o, 1'b1);
            check("vec_flit_data", flit_data_o, vecs[i].data);
            check("vec_flit_dst", flit_dst_o, vecs[i].exp_dst);
            check("vec_flit_src", flit_src_o, vecs[i].exp_src);
            check("vec_flit_seq", flit_seq_o, vecs[i].exp_seq);
            check("vec_flit_last", flit_last_o, vecs[i].exp_last);
            check("vec_out_flit", outstanding_o, vecs[i].exp_out_flit);
            ack_valid_i = vecs[i].ack;
            tick();
            ack_valid_i = 1'b0;
            check("vec_out_end", outstanding_o, vecs[i].exp_out_end);
            check("vec_flit_drained", flit_valid_o, 1'b0);
        end
        ack_pulse();
        ack_pulse();
        check("vec_out_zero", outstanding_o, '0);

        // ---- Back-to-back 4-beat burst, then next burst one cycle later ----
        for (int k = 0; k < 4; k++) d[k] = rand_data();
        id_i          = 4'd2;
        burst_valid_i = 1'b1;
        burst_dst_i   = 4'd6;
        burst_len_i   = 8'd3;
        data_valid_i  = 1'b1;
        data_i        = d[0];
        #1;
        check("b2b_first_accept", burst_ready_o, 1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            data_i = d[k];
            #1;
            check("b2b_data_ready", data_ready_o, 1'b1);
            check("b2b_no_desc", burst_ready_o, 1'b0);
            tick();
            check("b2b_valid", flit_valid_o, 1'b1);
            check("b2b_seq", flit_seq_o, k);
            check("b2b_last", flit_last_o, (k == 3));
            check("b2b_data", flit_data_o, d[k]);
        end
        burst_dst_i = 4'd8;
        burst_len_i = 8'd0;
        #1;
        check("b2b_next_accept", burst_ready_o, 1'b1);
        tick();
        burst_valid_i = 1'b0;
        data_i        = rand_data();
        tick();
        data_valid_i  = 1'b0;
        check("b2b_next_dst", flit_dst_o, 4'd8);
        tick();
        ack_pulse();
        ack_pulse();

        // ---- Backpressure mid-burst ----
        id_i          = 4'd9;
        burst_dst_i   = 4'd11;
        burst_len_i   = 8'd7;
        burst_valid_i = 1'b1;
        tick();
        burst_valid_i = 1'b0;
        base          = n_flits;
        data_valid_i  = 1'b1;
        for (int b = 0; b < 3; b++) begin
            data_i = rand_data();
            tick();
        end
        flit_ready_i = 1'b0;
        for (int s = 0; s < 5; s++) begin
            data_i = rand_data();
            #1;
            check("bp_data_ready", data_ready_o, 1'b0);
            check("bp_valid_held", flit_valid_o, 1'b1);
            check("bp_seq_held", flit_seq_o, 8'd2);
            tick();
        end
        flit_ready_i = 1'b1;
        for (int g = 0; g < 50 && (m_beats_left > 0 || m_valid); g++) begin
            data_i = rand_data();
            tick();
        end
        data_valid_i = 1'b0;
        check("bp_flit_count", n_flits - base, 8);
        ack_pulse();

        // ---- Outstanding limit ----
        for (int i = 0; i < MO; i++) send_burst(IW'(i + 1), 8'd0);
        tick();
        check("limit_out_full", outstanding_o, MO);
        burst_valid_i = 1'b1;
        burst_dst_i   = 4'd1;
        burst_len_i   = 8'd0;
        #1;
        check("limit_blocked", burst_ready_o, 1'b0);
        tick();
        tick();
        ack_valid_i = 1'b1;
        tick();
        // Count is now 3: this cycle has the handshake and an ack together.
        #1;
        check("limit_reenable", burst_ready_o, 1'b1);
        tick();
        burst_valid_i = 1'b0;
        ack_valid_i   = 1'b0;
        check("limit_simul_hold", outstanding_o, 3'd3);
        data_valid_i = 1'b1;
        data_i       = rand_data();
        tick();
        data_valid_i = 1'b0;
        tick();
        for (int i = 0; i < 3; i++) ack_pulse();
        check("limit_drained", outstanding_o, '0);

        // ---- Spurious ack ----
        ack_pulse();
        check("spur_err", err_o, 1'b1);
        check("spur_out", outstanding_o, '0);
        tick();
        tick();
        check("spur_err_sticky", err_o, 1'b1);
        ack_pulse();
        check("spur_out_again", outstanding_o, '0);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        check("spur_err_cleared", err_o, 1'b0);

        // ---- Reset mid-burst ----
        id_i          = 4'd12;
        burst_dst_i   = 4'd3;
        burst_len_i   = 8'd7;
        burst_valid_i = 1'b1;
        tick();
        burst_valid_i = 1'b0;
        data_valid_i  = 1'b1;
        for (int b = 0; b < 2; b++) begin
            data_i = rand_data();
            tick();
        end
        rst_i = 1'b1;
        tick();
        check("rstmid_valid", flit_valid_o, 1'b0);
        check("rstmid_out", outstanding_o, '0);
        rst_i         = 1'b0;
        data_valid_i  = 1'b0;
        burst_dst_i   = 4'd4;
        burst_len_i   = 8'd1;
        burst_valid_i = 1'b1;
        tick();
        burst_valid_i = 1'b0;
        data_valid_i  = 1'b1;
        data_i        = rand_data();
        tick();
        check("rstmid_new_seq0", flit_seq_o, 8'd0);
        check("rstmid_new_dst", flit_dst_o, 4'd4);
        data_i = rand_data();
        tick();
        data_valid_i = 1'b0;
        check("rstmid_new_seq1", flit_seq_o, 8'd1);
        check("rstmid_new_last", flit_last_o, 1'b1);
        tick();
        ack_pulse();

        // ---- Maximum length burst with random router stalls ----
        id_i          = 4'd1;
        burst_dst_i   = 4'd14;
        burst_len_i   = 8'hFF;
        burst_valid_i = 1'b1;
        tick();
        burst_valid_i = 1'b0;
        base          = n_flits;
        data_valid_i  = 1'b1;
        for (int g = 0; g < 2000 && (m_beats_left > 0 || m_valid); g++) begin
            flit_ready_i = ($urandom_range(0, 3) != 0);
            data_i       = rand_data();
            tick();
        end
        data_valid_i = 1'b0;
        flit_ready_i = 1'b1;
        check("maxlen_flit_count", n_flits - base, 256);
        ack_pulse();

        // ---- Randomized traffic against the model ----
        for (int c = 0; c < 1500; c++) begin
            rst_i         = ($urandom_range(0, 299) == 0);
            id_i          = IW'($urandom);
            burst_valid_i = ($urandom_range(0, 2) == 0);
            burst_dst_i   = IW'($urandom);
            burst_len_i   = LW'($urandom_range(0, 5));
            data_valid_i  = ($urandom_range(0, 3) != 0);
            data_i        = rand_data();
            flit_ready_i  = ($urandom_range(0, 3) != 0);
            ack_valid_i   = ($urandom_range(0, 5) == 0);
            tick();
        end
        rst_i         = 1'b0;
        burst_valid_i = 1'b0;
        data_valid_i  = 1'b0;
        ack_valid_i   = 1'b0;
        flit_ready_i  = 1'b1;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
